// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Build option: DMEM_WAIT_INJECT_EN enables pseudo-random extra load latency.
package dmem_responder_pkg;

    localparam int DMEM_ADDR_WIDTH = 12;
    localparam int CNT_W           = 5;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Fibonacci form of x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// Word-wide RAM with per-byte write enables and combinational read.
// Contents are not cleared by reset.
module dmem_sram_bank #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: byte-strobed stores, handshaked load words.
// Build option: DMEM_WAIT_INJECT_EN adds 0..3 LFSR-chosen wait cycles per load.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    dmem_state_e           state;
    dmem_state_e           state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_init;
    logic [ADDR_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           ram_rdata;
    logic [31:0]           rdata_q;
    logic                  store_go;
    logic                  load_go;
    logic                  resp_load;

    // Upper address bits and byte offset alias onto the same word
    logic unused_addr;
    assign unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

    assign word          = Address[ADDR_WIDTH+1:2];
    assign Mem_Req_Ready = (state == DMEM_IDLE) && !reset;
    assign store_go      = MemWrite && Mem_Req_Ready;
    assign load_go       = MemRead && !MemWrite && Mem_Req_Ready;
    assign resp_load     = (state == DMEM_WAIT) && (cnt == '0);

`ifdef DMEM_WAIT_INJECT_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= lfsr_step(lfsr);
    end

    assign cnt_init = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
    assign cnt_init = CNT_W'(LATENCY - 1);
`endif

    dmem_sram_bank #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
        .clk  (clk),
        .we   (store_go ? Write_strb : 4'b0000),
        .waddr(word),
        .wdata(Write_data),
        .raddr(idx),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= DMEM_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DMEM_IDLE: if (load_go)         state_nxt = DMEM_WAIT;
            DMEM_WAIT: if (cnt == '0)       state_nxt = DMEM_RESP;
            DMEM_RESP: if (Read_data_Ready) state_nxt = DMEM_IDLE;
            default:                        state_nxt = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            rdata_q <= '0;
        end else begin
            if (load_go) begin
                cnt <= cnt_init;
                idx <= word;
            end else if (state == DMEM_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (resp_load) rdata_q <= ram_rdata;
        end
    end

    assign Read_data_Valid = (state == DMEM_RESP) && !reset;
    assign Read_data       = reset ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=1 and LATENCY=3 instances.
// Define DMEM_WAIT_INJECT_EN to add the random latency run.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_we, a_rd, a_req_rdy, a_valid, a_rdy;
    logic [31:0] a_addr, a_wd, a_rdata;
    logic [3:0]  a_strb;
    logic        b_reset, b_we, b_rd, b_req_rdy, b_valid, b_rdy;
    logic [31:0] b_addr, b_wd, b_rdata;
    logic [3:0]  b_strb;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    dmem_responder #(.ADDR_WIDTH(12), .LATENCY(1)) dut_a (
        .clk(clk), .reset(a_reset), .Address(a_addr),
        .MemWrite(a_we), .MemRead(a_rd), .Write_data(a_wd),
        .Write_strb(a_strb), .Mem_Req_Ready(a_req_rdy),
        .Read_data(a_rdata), .Read_data_Valid(a_valid),
        .Read_data_Ready(a_rdy)
    );

    dmem_responder #(.ADDR_WIDTH(12), .LATENCY(3)) dut_b (
        .clk(clk), .reset(b_reset), .Address(b_addr),
        .MemWrite(b_we), .MemRead(b_rd), .Write_data(b_wd),
        .Write_strb(b_strb), .Mem_Req_Ready(b_req_rdy),
        .Read_data(b_rdata), .Read_data_Valid(b_valid),
        .Read_data_Ready(b_rdy)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every handshaked response must match the next queued word
    always @(negedge clk) begin
        if (a_valid && a_rdy) begin
            if (q_a.size() == 0) check("a_unexpected_resp", a_valid, 0);
            else                 check("a_resp_data", a_rdata, q_a.pop_front());
        end
        if (b_valid && b_rdy) begin
            if (q_b.size() == 0) check("b_unexpected_resp", b_valid, 0);
            else                 check("b_resp_data", b_rdata, q_b.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wait_ready();
        int n = 0;
        while (!a_req_rdy && n < 50) begin
            tick();
            n++;
        end
        check("a_req_ready_wait", a_req_rdy, 1);
    endtask

    task automatic a_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
        a_wait_ready();
        a_addr = addr;
        a_wd   = data;
        a_strb = strb;
        a_we   = 1'b1;
        tick();
        a_we   = 1'b0;
    endtask

    task automatic a_load(input logic [31:0] addr, input logic [31:0] exp);
        a_wait_ready();
        a_addr = addr;
        a_rd   = 1'b1;
        q_a.push_back(exp);
        tick();
        a_rd   = 1'b0;
    endtask

    task automatic a_wait_valid(input string name);
        int n = 0;
        while (!a_valid && n < 30) begin
            tick();
            n++;
        end
        check(name, a_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check("queue_a_empty", q_a.size(), 0);
        check("queue_b_empty", q_b.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        a_reset = 1'b1; a_we = 1'b0; a_rd = 1'b0; a_rdy = 1'b1;
        a_addr = '0; a_wd = '0; a_strb = '0;
        b_reset = 1'b1; b_we = 1'b0; b_rd = 1'b0; b_rdy = 1'b1;
        b_addr = '0; b_wd = '0; b_strb = '0;

        // Reset state, with Ready high being ignored
        repeat (3) tick();
        check("rst_valid", a_valid, 0);
        check("rst_req_ready", a_req_rdy, 0);
        check("rst_rdata", a_rdata, 32'h0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        #1;
        check("post_rst_req_ready", a_req_rdy, 1);

        // Full-word store then load, one-cycle latency
        a_store(32'h100, 32'h1234_5678, 4'hF);
        a_wait_ready();
        a_addr = 32'h100;
        a_rd   = 1'b1;
        q_a.push_back(32'h1234_5678);
        tick();
        a_rd = 1'b0;
`ifndef DMEM_WAIT_INJECT_EN
        check("t1_valid_at_T", a_valid, 0);
        tick();
        check("t1_valid_at_T1", a_valid, 1);
        check("t1_rdata", a_rdata, 32'h1234_5678);
`endif
        drain();

        // Single-lane store merges into existing word
        a_store(32'h101, 32'h0000_AB00, 4'b0010);
        a_load(32'h100, 32'h1234_AB78);
        drain();

        // Backpressure: aliased address, response held for 5 cycles
        a_rdy = 1'b0;
        a_load(32'h4100, 32'h1234_AB78);
        a_wait_valid("t3_valid_seen");
        repeat (5) begin
            tick();
            check("t3_valid_hold", a_valid, 1);
            check("t3_rdata_hold", a_rdata, 32'h1234_AB78);
            check("t3_req_ready_low", a_req_rdy, 0);
        end
        a_rdy = 1'b1;
        tick();
        check("t3_req_ready_after", a_req_rdy, 1);
        check("t3_valid_after", a_valid, 0);

        // Store and load together: store wins, no response
        a_wait_ready();
        a_addr = 32'h200; a_wd = 32'hCAFE_F00D; a_strb = 4'hF;
        a_we = 1'b1; a_rd = 1'b1;
        tick();
        a_we = 1'b0; a_rd = 1'b0;
        repeat (3) tick();
        check("conflict_no_resp", a_valid, 0);
        a_load(32'h200, 32'hCAFE_F00D);
        drain();

        // LATENCY=3 instance: exact response timing
        check("b_req_ready_idle", b_req_rdy, 1);
        b_addr = 32'h300; b_wd = 32'h55AA_33CC; b_strb = 4'hF; b_we = 1'b1;
        tick();
        b_we = 1'b0;
        b_rd = 1'b1;
        q_b.push_back(32'h55AA_33CC);
        tick();
        b_rd = 1'b0;
`ifndef DMEM_WAIT_INJECT_EN
        check("t4_valid_T", b_valid, 0);
        tick();
        check("t4_valid_T1", b_valid, 0);
        tick();
        check("t4_valid_T2", b_valid, 0);
        tick();
        check("t4_valid_T3", b_valid, 1);
        check("t4_rdata", b_rdata, 32'h55AA_33CC);
`endif
        drain();
        check("t4_req_ready_after", b_req_rdy, 1);

        // Reset while a load is waiting drops it
        b_rd = 1'b1;
        tick();
        b_rd = 1'b0;
        tick();
        b_reset = 1'b1;
        #1;
        check("t5_valid_in_reset", b_valid, 0);
        check("t5_req_ready_in_reset", b_req_rdy, 0);
        tick();
        b_reset = 1'b0;
        #1;
        check("t5_valid_after_reset", b_valid, 0);
        check("t5_req_ready_after_reset", b_req_rdy, 1);
        repeat (6) begin
            tick();
            check("t5_no_stale_resp", b_valid, 0);
        end

        // RAM survives a reset of instance A
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        a_load(32'h100, 32'h1234_AB78);
        drain();

`ifdef DMEM_WAIT_INJECT_EN
        for (int i = 0; i < 100; i++) begin
            logic [31:0] addr;
            logic [31:0] data;
            int lat;
            addr = 32'h800 + {$urandom_range(0, 63), 2'b00};
            data = $urandom;
            a_store(addr, data, 4'hF);
            a_load(addr, data);
            lat = 0;
            while (!a_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("t6_latency_range", (lat >= 1 && lat <= 4), 1);
            tick();
        end
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
